// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin arbiter sharing one async_fifo enqueue port among NREQ burst requesters
module fifo_enq_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ = 4,
  parameter int MAXBEATS = 16,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(MAXBEATS + 1)
) (
  input  logic                  enq_clk,
  input  logic                  enq_rst_n,
  input  logic [NREQ*DSIZE-1:0] req_bits,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      enq_bits,
  output logic                  enq_valid,
  input  logic                  enq_ready,
  output logic [NREQ-1:0]       grant,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [NREQ-1:0] grant_d;
  logic [IW-1:0] grant_id_d, rr_ptr, rr_d, sel, cand;
  logic [CW-1:0] beat_cnt, cnt_d;
  logic [NREQ-1:0][DSIZE-1:0] beats;
  logic acc, rel;
  assign beats = req_bits;
  assign busy = state == GRANT;
  // grant is all-zero in IDLE, so these gates keep the FIFO port quiet outside GRANT
  assign enq_valid = |(grant & req_valid);
  assign req_ready = grant & {NREQ{enq_ready}};
  assign enq_bits = busy ? beats[grant_id] : '0;
  assign acc = enq_valid & enq_ready;
  assign rel = acc & (req_last[grant_id] | (beat_cnt == CW'(MAXBEATS - 1)));
  // walk offsets from high to low so the nearest requester at or above rr_ptr wins
  always_comb begin
    sel = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (req_valid[cand]) sel = cand;
    end
  end
  always_comb begin
    state_d = state;
    grant_d = grant;
    grant_id_d = grant_id;
    rr_d = rr_ptr;
    cnt_d = beat_cnt;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_d = GRANT;
        grant_d = NREQ'(1) << sel;
        grant_id_d = sel;
        cnt_d = '0;
      end
    end else begin
      cnt_d = acc ? beat_cnt + 1'b1 : beat_cnt;
      if (rel) begin
        state_d = IDLE;
        grant_d = '0;
        grant_id_d = '0;
        rr_d = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end
  always_ff @(posedge enq_clk) begin
    if (!enq_rst_n) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      grant_id <= grant_id_d;
      rr_ptr <= rr_d;
      beat_cnt <= cnt_d;
    end
  end
endmodule
